// File: rtl/sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : sig_gen
// Purpose  : Programmable pulse-train generator. A configuration (period,
//            high time, burst length) is offered through a valid/ready
//            handshake, checked for legality and held in a shadow register.
//            It becomes active immediately when idle, or at the next period
//            boundary while running, so no pulse is ever truncated or stretched.
//            It runs continuously or for a fixed number of pulses (burst).
// Ports    : sys_clk    - single clock, rising edge
//            rst_n      - asynchronous active-low reset
//            cfg_valid  - configuration offer
//            cfg_ready  - no configuration pending in the shadow register
//            cfg_period - period in sys_clk cycles
//            cfg_high   - high time per period in sys_clk cycles
//            cfg_burst  - pulses per burst, 0 = continuous
//            enable     - run request, level sensitive
//            sig_out    - registered waveform
//            busy       - generator is running
//            pulse_cnt  - pulses emitted since the last start (saturating)
//            done       - one-cycle pulse at the end of a burst
//            cfg_err    - one-cycle pulse when an accepted config is illegal
// Revision : 1.0 - initial release
// ============================================================================
module sig_gen #(
  parameter int CNT_WIDTH  = 32,
  parameter int MIN_PERIOD = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_high,
  input  logic [CNT_WIDTH-1:0] cfg_burst,
  input  logic                 enable,
  output logic                 sig_out,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pulse_cnt,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_one        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_min_period = CNT_WIDTH'(MIN_PERIOD);

  state_t                 state_q,      state_d;
  logic [CNT_WIDTH-1:0]   phase_q,      phase_d;
  logic                   sig_out_q,    sig_out_d;
  logic                   busy_q,       busy_d;
  logic                   done_q,       done_d;
  logic                   cfg_err_q,    cfg_err_d;
  logic [CNT_WIDTH-1:0]   pulse_cnt_q,  pulse_cnt_d;
  logic                   pending_q,    pending_d;
  logic                   loaded_q,     loaded_d;
  logic                   armed_q,      armed_d;
  logic [CNT_WIDTH-1:0]   sh_period_q,  sh_period_d;
  logic [CNT_WIDTH-1:0]   sh_high_q,    sh_high_d;
  logic [CNT_WIDTH-1:0]   sh_burst_q,   sh_burst_d;
  logic [CNT_WIDTH-1:0]   act_period_q, act_period_d;
  logic [CNT_WIDTH-1:0]   act_high_q,   act_high_d;
  logic [CNT_WIDTH-1:0]   act_burst_q,  act_burst_d;

  logic                   w_accept;
  logic                   w_illegal;
  logic                   w_boundary;
  logic [CNT_WIDTH-1:0]   w_phase_inc;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic                   w_burst_end;
  logic                   w_start;

  assign w_accept    = cfg_valid && !pending_q;
  assign w_illegal   = (cfg_period < c_min_period) || (cfg_high == '0) ||
                       (cfg_high >= cfg_period);
  assign w_boundary  = (phase_q == (act_period_q - c_one));
  assign w_phase_inc = phase_q + c_one;
  assign w_cnt_inc   = (pulse_cnt_q == '1) ? pulse_cnt_q : (pulse_cnt_q + c_one);
  assign w_burst_end = (act_burst_q != '0) && (pulse_cnt_q >= act_burst_q);
  // A finished burst must not retrigger while enable is simply held high;
  // armed_q is re-set once enable is seen low in IDLE.
  assign w_start     = enable && loaded_q && (armed_q || (act_burst_q == '0));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sig_out_d    = sig_out_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    pulse_cnt_d  = pulse_cnt_q;
    pending_d    = pending_q;
    loaded_d     = loaded_q;
    armed_d      = armed_q;
    sh_period_d  = sh_period_q;
    sh_high_d    = sh_high_q;
    sh_burst_d   = sh_burst_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    act_burst_d  = act_burst_q;

    // Accept is only possible with pending_q low, and the shadow-to-active
    // copy only with pending_q high, so the two never collide.
    if (w_accept) begin
      if (w_illegal) begin
        cfg_err_d = 1'b1;
      end else begin
        sh_period_d = cfg_period;
        sh_high_d   = cfg_high;
        sh_burst_d  = cfg_burst;
        pending_d   = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        sig_out_d = 1'b0;
        if (!enable) begin
          armed_d = 1'b1;
        end
        if (pending_q) begin
          act_period_d = sh_period_q;
          act_high_d   = sh_high_q;
          act_burst_d  = sh_burst_q;
          pending_d    = 1'b0;
          loaded_d     = 1'b1;
        end
        if (w_start) begin
          state_d     = ST_RUN;
          phase_d     = '0;
          sig_out_d   = 1'b1;
          pulse_cnt_d = c_one;
        end
      end

      ST_RUN: begin
        if (w_boundary) begin
          // Stop decisions use the configuration that governed this period.
          if (w_burst_end) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            sig_out_d = 1'b0;
            armed_d   = 1'b0;
          end else if ((act_burst_q == '0) && !enable) begin
            state_d   = ST_IDLE;
            sig_out_d = 1'b0;
          end else begin
            phase_d     = '0;
            sig_out_d   = 1'b1;
            pulse_cnt_d = w_cnt_inc;
            if (pending_q) begin
              act_period_d = sh_period_q;
              act_high_d   = sh_high_q;
              act_burst_d  = sh_burst_q;
              pending_d    = 1'b0;
            end
          end
        end else begin
          phase_d   = w_phase_inc;
          sig_out_d = (w_phase_inc < act_high_q);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        sig_out_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      sig_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      pulse_cnt_q  <= '0;
      pending_q    <= 1'b0;
      loaded_q     <= 1'b0;
      armed_q      <= 1'b1;
      sh_period_q  <= '0;
      sh_high_q    <= '0;
      sh_burst_q   <= '0;
      act_period_q <= '0;
      act_high_q   <= '0;
      act_burst_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sig_out_q    <= sig_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      pulse_cnt_q  <= pulse_cnt_d;
      pending_q    <= pending_d;
      loaded_q     <= loaded_d;
      armed_q      <= armed_d;
      sh_period_q  <= sh_period_d;
      sh_high_q    <= sh_high_d;
      sh_burst_q   <= sh_burst_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      act_burst_q  <= act_burst_d;
    end
  end

  assign cfg_ready = !pending_q;
  assign sig_out   = sig_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_gen
// Purpose  : Self-checking bench for sig_gen. Each scenario pushes the
//            expected per-cycle outputs into a scoreboard queue as stimulus is
//            driven; every clock the oldest entry is popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sig_gen;

  localparam int CW = 32;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_high;
  logic [CW-1:0] cfg_burst;
  logic          enable;
  logic          sig_out;
  logic          busy;
  logic [CW-1:0] pulse_cnt;
  logic          done;
  logic          cfg_err;

  int    assert_cnt = 0;
  int    fail_cnt   = 0;
  string scn        = "init";

  typedef struct packed {
    logic        sig;
    logic        bsy;
    logic        dn;
    logic        err;
    logic        rdy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 sys_clk = ~sys_clk;

  sig_gen #(
    .CNT_WIDTH  (CW),
    .MIN_PERIOD (2)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_burst  (cfg_burst),
    .enable     (enable),
    .sig_out    (sig_out),
    .busy       (busy),
    .pulse_cnt  (pulse_cnt),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert_cnt++;
    if (obs !== expv) begin
      fail_cnt++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", scn, tag, obs, expv, $time);
    end
  endtask

  task automatic push(input logic s, input logic b, input logic d, input logic e,
                      input logic r, input logic [31:0] c);
    exp_t x;
    x.sig = s; x.bsy = b; x.dn = d; x.err = e; x.rdy = r; x.cnt = c;
    exp_q.push_back(x);
  endtask

  task automatic push_idle(input logic r, input logic [31:0] c);
    push(1'b0, 1'b0, 1'b0, 1'b0, r, c);
  endtask

  // Running waveform: phase counts 0..p-1, high for phases below h,
  // pulse count steps at every new period.
  task automatic push_run(input int p, input int h, input int ph0, input int cnt0, input int n);
    for (int k = 0; k < n; k++) begin
      push(((ph0 + k) % p) < h, 1'b1, 1'b0, 1'b0, 1'b1, 32'(cnt0 + (ph0 + k) / p));
    end
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sig_out",   32'(sig_out),   32'(e.sig));
        check_eq("busy",      32'(busy),      32'(e.bsy));
        check_eq("done",      32'(done),      32'(e.dn));
        check_eq("cfg_err",   32'(cfg_err),   32'(e.err));
        check_eq("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
        check_eq("pulse_cnt", pulse_cnt,      e.cnt);
      end
    end
  endtask

  task automatic cfg_offer(input int p, input int h, input int b);
    cfg_valid  = 1'b1;
    cfg_period = 32'(p);
    cfg_high   = 32'(h);
    cfg_burst  = 32'(b);
    run_cycles(1);
    cfg_valid  = 1'b0;
  endtask

  task automatic check_reset_values();
    check_eq("rst_sig_out",   32'(sig_out),   32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_done",      32'(done),      32'd0);
    check_eq("rst_cfg_err",   32'(cfg_err),   32'd0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_pulse_cnt", pulse_cnt,      32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_burst  = '0;
    enable     = 1'b1;
    #1;
    scn = "reset";
    check_reset_values();
    #11 rst_n = 1'b1;

    // Enable alone does nothing without a loaded configuration.
    scn = "no_cfg";
    repeat (3) push_idle(1'b1, 0);
    run_cycles(3);
    enable = 1'b0;
    push_idle(1'b1, 0);
    run_cycles(1);

    // Continuous 5/2, with a short enable glitch inside a period.
    scn = "cont_5_2";
    push_idle(1'b0, 0);
    cfg_offer(5, 2, 0);
    push_idle(1'b1, 0);
    run_cycles(1);
    push_run(5, 2, 0, 1, 10);
    enable = 1'b1;
    run_cycles(3);
    enable = 1'b0;
    run_cycles(2);
    enable = 1'b1;
    run_cycles(5);
    enable = 1'b0;
    push_idle(1'b1, 2);
    push_idle(1'b1, 2);
    run_cycles(2);

    // Burst of 3 with period 4 / high 1; held enable must not retrigger.
    scn = "burst_4_1_3";
    push_idle(1'b0, 2);
    cfg_offer(4, 1, 3);
    push_idle(1'b1, 2);
    run_cycles(1);
    enable = 1'b1;
    push_run(4, 1, 0, 1, 12);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    repeat (3) push_idle(1'b1, 3);
    run_cycles(16);
    enable = 1'b0;
    push_idle(1'b1, 3);
    run_cycles(1);
    enable = 1'b1;
    push_run(4, 1, 0, 1, 12);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    run_cycles(13);
    enable = 1'b0;
    push_idle(1'b1, 3);
    run_cycles(1);

    // Reconfigure mid-period: 6/3 finishes, then 4/2 takes over.
    scn = "reload";
    push_idle(1'b0, 3);
    cfg_offer(6, 3, 0);
    push_idle(1'b1, 3);
    run_cycles(1);
    enable = 1'b1;
    push_run(6, 3, 0, 1, 2);
    run_cycles(2);
    for (int ph = 2; ph < 6; ph++) push(ph < 3, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    cfg_offer(4, 2, 0);
    run_cycles(3);
    push_run(4, 2, 0, 2, 8);
    run_cycles(8);
    enable = 1'b0;
    push_idle(1'b1, 3);
    run_cycles(1);

    // Illegal offers while running 4/2: error pulse, waveform untouched.
    scn = "illegal";
    for (int k = 0; k < 8; k++) begin
      push((k % 4) < 2, 1'b1, 1'b0, (k == 1) || (k == 3) || (k == 5), 1'b1, 32'(k / 4 + 1));
    end
    push_run(4, 2, 0, 3, 4);
    enable = 1'b1;
    run_cycles(1);
    cfg_offer(1, 1, 0);
    run_cycles(1);
    cfg_offer(8, 0, 0);
    run_cycles(1);
    cfg_offer(8, 8, 0);
    run_cycles(6);
    enable = 1'b0;
    push_idle(1'b1, 3);
    run_cycles(1);

    // Continuous 10/5, enable dropped at phase 2: period completes, no done.
    scn = "stop_cont";
    push_idle(1'b0, 3);
    cfg_offer(10, 5, 0);
    push_idle(1'b1, 3);
    run_cycles(1);
    enable = 1'b1;
    push_run(10, 5, 0, 1, 3);
    run_cycles(3);
    enable = 1'b0;
    push_run(10, 5, 3, 1, 7);
    run_cycles(7);
    push_idle(1'b1, 1);
    push_idle(1'b1, 1);
    run_cycles(2);

    // Reset while sig_out is high; afterwards a new config is required.
    scn = "reset_mid";
    enable = 1'b1;
    push_run(10, 5, 0, 1, 2);
    run_cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge sys_clk);
    #3 rst_n = 1'b1;
    repeat (4) push_idle(1'b1, 0);
    run_cycles(4);
    push_idle(1'b0, 0);
    cfg_offer(3, 1, 0);
    push_idle(1'b1, 0);
    run_cycles(1);
    push_run(3, 1, 0, 1, 3);
    run_cycles(3);
    enable = 1'b0;
    push_idle(1'b1, 1);
    run_cycles(1);

    scn = "end";
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
